programmable_counting_element: RTL and testbench

//  Parametrised, mode-capable successor of the 8254 counting element: a WIDTH-bit down-counter with gate, reload,

---
 rtl/programmable_counting_element.sv | 169 ++++++++++++++++
 tb/tb_programmable_counting_element.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/programmable_counting_element.sv
// -----------------------------------------------------------------------------
// programmable_counting_element
//   WIDTH-bit down-counter that generates an 8254-style channel output. It has
//   three modes: terminal count (0, with 1 aliased to 0), rate generator (2)
//   and square wave (3). Counting advances once per clk cycle in which ce_tick
//   is high. An optional read-back snapshot is built when CE_LATCH_EN is
//   defined; without it, read_value shows the live count.
//
// Ports
//   clk         system clock; all state changes on posedge
//   rst         synchronous reset, active-high
//   ce_tick     count strobe
//   gate        count enable; a rising edge restarts the period in modes 2/3
//   mode        requested mode, sampled on load
//   load        1-cycle pulse: take load_value and mode
//   load_value  initial / reload count (0 means 2**WIDTH)
//   latch_cmd   1-cycle pulse: snapshot the count (CE_LATCH_EN only)
//   read_ack    1-cycle pulse: release the snapshot (CE_LATCH_EN only)
//   read_value  count value for the read path
//   out         registered channel output waveform
//   count_end   high while the count register is zero
// -----------------------------------------------------------------------------
module programmable_counting_element #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_tick,
  input  logic             gate,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             latch_cmd,
  input  logic             read_ack,
  output logic [WIDTH-1:0] read_value,
  output logic             out,
  output logic             count_end
);

  localparam logic [1:0] MODE_TC     = 2'd0;
  localparam logic [1:0] MODE_RATE   = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd3;

  // A count of zero stands for 2**WIDTH, so period arithmetic is one bit wider.
  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic [1:0]       mode_q;
  logic             armed;
  logic             gate_q;

  logic             periodic;
  logic             gate_rise;
  logic [WIDTH:0]   period;
  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   nxt;
  logic             out_periodic;
  logic [WIDTH-1:0] load_count;

  assign periodic  = mode_q[1];
  assign gate_rise = gate & ~gate_q;
  assign count_end = (count == '0);

  // Period arithmetic for modes 2/3. A reload of 1 acts as 2, so out still
  // spends one tick low in each period.
  // NOTE: each always_comb output gets a default first, so every path assigns
  // it and no latch is inferred.
  always_comb begin
    period       = {1'b0, reload};
    cur          = {1'b0, count};
    nxt          = '0;
    out_periodic = 1'b1;
    load_count   = load_value;

    if (reload == '0)
      period = FULL;
    else if (reload == WIDTH'(1))
      period = (WIDTH+1)'(2);

    if (count == '0)
      cur = FULL;

    if (cur == (WIDTH+1)'(1))
      nxt = period;
    else
      nxt = cur - (WIDTH+1)'(1);

    // Mode 3: out stays high while the remaining ticks exceed floor(N/2).
    // This gives ceil(N/2) ticks high and floor(N/2) ticks low.
    // Mode 2: out is low only in the last tick of the period.
    if (mode_q == MODE_SQUARE)
      out_periodic = (nxt > (period >> 1));
    else
      out_periodic = (nxt != (WIDTH+1)'(1));

    if (mode[1] && (load_value == WIDTH'(1)))
      load_count = WIDTH'(2);
  end

  // NOTE: registered state uses non-blocking assignments, so every register
  // here sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      mode_q <= MODE_TC;
      armed  <= 1'b0;
      out    <= 1'b1;
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate;
      if (load) begin
        // Load aborts any period in progress and takes priority over ticks.
        count  <= load_count;
        reload <= load_value;
        mode_q <= mode;
        armed  <= 1'b1;
        out    <= mode[1];
      end else if (periodic && armed) begin
        if (!gate) begin
          out <= 1'b1;
        end else if (gate_rise) begin
          count <= period[WIDTH-1:0];
          out   <= 1'b1;
        end else if (ce_tick) begin
          count <= nxt[WIDTH-1:0];
          out   <= out_periodic;
        end
      end else if (armed && gate && ce_tick) begin
        // Terminal count: stop at zero and wait for the next load.
        if (count == WIDTH'(1)) begin
          count <= '0;
          out   <= 1'b1;
          armed <= 1'b0;
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

`ifdef CE_LATCH_EN
  logic [WIDTH-1:0] snapshot;
  logic             snap_valid;

  // NOTE: the snapshot is a single register, not a memory, so it is reset like
  // the other state. read_value is then defined from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot   <= '0;
      snap_valid <= 1'b0;
    end else if (latch_cmd && (!snap_valid || read_ack)) begin
      // An ack in the same cycle frees the holder, so the new snapshot is taken.
      snapshot   <= count;
      snap_valid <= 1'b1;
    end else if (read_ack) begin
      snap_valid <= 1'b0;
    end
  end

  assign read_value = snap_valid ? snapshot : count;
`else
  logic unused_latch;
  assign unused_latch = latch_cmd ^ read_ack;
  assign read_value   = count;
`endif

endmodule

// File: tb/tb_programmable_counting_element.sv
module tb_programmable_counting_element;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ce_tick = 1'b0;
  logic             gate = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             latch_cmd = 1'b0;
  logic             read_ack = 1'b0;
  logic [WIDTH-1:0] read_value;
  logic             out;
  logic             count_end;

  int n_cmp  = 0;
  int n_fail = 0;

  programmable_counting_element #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_tick   (ce_tick),
    .gate      (gate),
    .mode      (mode),
    .load      (load),
    .load_value(load_value),
    .latch_cmd (latch_cmd),
    .read_ack  (read_ack),
    .read_value(read_value),
    .out       (out),
    .count_end (count_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             load;
    logic [1:0]       mode;
    logic [WIDTH-1:0] val;
    logic             gate;
    logic             ce;
    logic [WIDTH-1:0] exp_read;
    logic             exp_out;
    logic             exp_end;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are changed 1 time unit after a posedge and outputs are sampled at
  // the same offset, well away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic ld, input logic [1:0] m,
                       input logic [WIDTH-1:0] v, input logic g, input logic ce);
    rst = r; load = ld; mode = m; load_value = v; gate = g; ce_tick = ce;
  endtask

  task automatic expect_state(input string name, input logic [WIDTH-1:0] rd,
                              input logic o, input logic e);
    check({name, ".read"}, 32'(read_value), 32'(rd));
    check({name, ".out"},  32'(out), 32'(o));
    check({name, ".end"},  32'(count_end), 32'(e));
  endtask

  function automatic void add(input logic r, input logic ld, input logic [1:0] m,
                              input logic [WIDTH-1:0] v, input logic g, input logic ce,
                              input logic [WIDTH-1:0] rd, input logic o, input logic e);
    vec_t t;
    t = '{r, ld, m, v, g, ce, rd, o, e};
    vecs.push_back(t);
  endfunction

  initial begin
    // Reset, plus reset beating a same-cycle load
    add(1,0,0,0,1,1,      0,1,1);
    add(1,1,0,9,1,1,      0,1,1);
    // Mode 0, value 5: count 5..0, out rises at 0, then holds
    add(0,1,0,5,1,1,      5,0,0);
    add(0,0,0,0,1,1,      4,0,0);
    add(0,0,0,0,1,1,      3,0,0);
    add(0,0,0,0,1,1,      2,0,0);
    add(0,0,0,0,1,1,      1,0,0);
    add(0,0,0,0,1,1,      0,1,1);
    add(0,0,0,0,1,1,      0,1,1);
    add(0,0,0,0,1,1,      0,1,1);
    // Mode 0 gate low freezes the count
    add(0,1,0,3,1,1,      3,0,0);
    add(0,0,0,0,0,1,      3,0,0);
    add(0,0,0,0,0,1,      3,0,0);
    add(0,0,0,0,1,1,      2,0,0);
    // Mode 2, value 4: 4,3,2,1 with out 1,1,1,0; an idle ce_tick holds
    add(0,1,2,4,1,1,      4,1,0);
    add(0,0,0,0,1,1,      3,1,0);
    add(0,0,0,0,1,1,      2,1,0);
    add(0,0,0,0,1,1,      1,0,0);
    add(0,0,0,0,1,1,      4,1,0);
    add(0,0,0,0,1,0,      4,1,0);
    add(0,0,0,0,1,1,      3,1,0);
    add(0,0,0,0,1,1,      2,1,0);
    add(0,0,0,0,1,1,      1,0,0);
    add(0,0,0,0,1,1,      4,1,0);
    // Mode 3, value 5: 3 high, 2 low
    add(0,1,3,5,1,1,      5,1,0);
    add(0,0,0,0,1,1,      4,1,0);
    add(0,0,0,0,1,1,      3,1,0);
    add(0,0,0,0,1,1,      2,0,0);
    add(0,0,0,0,1,1,      1,0,0);
    add(0,0,0,0,1,1,      5,1,0);
    add(0,0,0,0,1,1,      4,1,0);
    // Mode 3, value 4: 2 high, 2 low (loaded mid-period)
    add(0,1,3,4,1,1,      4,1,0);
    add(0,0,0,0,1,1,      3,1,0);
    add(0,0,0,0,1,1,      2,0,0);
    add(0,0,0,0,1,1,      1,0,0);
    add(0,0,0,0,1,1,      4,1,0);
    // Mode 3, value 1 runs as period 2: 1 high, 1 low
    add(0,1,3,1,1,1,      2,1,0);
    add(0,0,0,0,1,1,      1,0,0);
    add(0,0,0,0,1,1,      2,1,0);
    add(0,0,0,0,1,1,      1,0,0);
    // Mode 1 behaves as mode 0
    add(0,1,1,2,1,1,      2,0,0);
    add(0,0,0,0,1,1,      1,0,0);
    add(0,0,0,0,1,1,      0,1,1);
    add(0,0,0,0,1,1,      0,1,1);

    step();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].mode, vecs[i].val, vecs[i].gate, vecs[i].ce);
      step();
      expect_state($sformatf("vec%0d", i), vecs[i].exp_read, vecs[i].exp_out, vecs[i].exp_end);
    end

    // Mode 2 gating: the count freezes, out is forced high, and a rising edge
    // restarts the period.
    drive(0,1,2,6,1,1); step(); expect_state("g_load", 6, 1, 0);
    drive(0,0,0,0,1,1); step(); step(); expect_state("g_run", 4, 1, 0);
    drive(0,0,0,0,0,1); step(); expect_state("g_low1", 4, 1, 0);
    step();                     expect_state("g_low2", 4, 1, 0);
    drive(0,0,0,0,1,1); step(); expect_state("g_rise", 6, 1, 0);
    step();                     expect_state("g_tick", 5, 1, 0);
    repeat (4) step();          expect_state("g_outlow", 1, 0, 0);
    drive(0,0,0,0,0,1); step(); expect_state("g_force", 1, 1, 0);
    drive(0,0,0,0,1,1); step(); expect_state("g_rise2", 6, 1, 0);

    // Load beats a same-cycle tick; load 0 spans 65536 ticks
    drive(0,1,0,16'h00A2,1,1); step();
    drive(0,0,0,0,1,1); step(); step(); expect_state("l_a0", 16'h00A0, 0, 0);
    drive(0,1,0,3,1,1);  step(); expect_state("l_wins", 3, 0, 0);
    drive(0,1,0,0,1,1);  step(); expect_state("l_zero", 0, 0, 1);
    drive(0,0,0,0,1,1);  step(); expect_state("l_wrap", 16'hFFFF, 0, 0);
    repeat (65534) step();       expect_state("l_last", 1, 0, 0);
    step();                      expect_state("l_done", 0, 1, 1);

    // Read-back path
    drive(0,1,0,100,1,0); step(); expect_state("r_load", 100, 0, 0);
    drive(0,0,0,0,1,0); latch_cmd = 1'b1; step(); latch_cmd = 1'b0;
    check("r_latch", 32'(read_value), 32'd100);
    ce_tick = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
`ifdef CE_LATCH_EN
      check($sformatf("r_hold%0d", i), 32'(read_value), 32'd100);
`else
      check($sformatf("r_live%0d", i), 32'(read_value), 32'(100 - i));
`endif
    end
    ce_tick = 1'b0;
    latch_cmd = 1'b1; step(); latch_cmd = 1'b0;
`ifdef CE_LATCH_EN
    check("r_relatch_ignored", 32'(read_value), 32'd100);
`else
    check("r_relatch_live", 32'(read_value), 32'd90);
`endif
    latch_cmd = 1'b1; read_ack = 1'b1; step(); latch_cmd = 1'b0; read_ack = 1'b0;
    check("r_ack_latch", 32'(read_value), 32'd90);
    ce_tick = 1'b1; repeat (5) step(); ce_tick = 1'b0;
`ifdef CE_LATCH_EN
    check("r_held90", 32'(read_value), 32'd90);
`else
    check("r_live85", 32'(read_value), 32'd85);
`endif
    read_ack = 1'b1; step(); read_ack = 1'b0;
    check("r_release", 32'(read_value), 32'd85);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
